aes_subbytes_engine: RTL and testbench
======================================

AES_SUBBYTES_ENGINE -- requirements
Module: aes_subbytes_engine

Interface
REQ-001 The block SHALL have parameter NBYTES, default 16, giving the number of state bytes per block.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of S-box lanes applied per cycle; legal values satisfy 1 <= LANES <= NBYTES and NBYTES % LANES == 0.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous abort that returns the block to IDLE.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an input block is offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the engine can accept a block.
REQ-008 The block SHALL have port in_data, input, 8*NBYTES bits: state bytes, with byte i at bits [8i+7:8i].
REQ-009 The block SHALL have port in_inv, input, 1 bit: 0 selects the forward AES S-box, 1 selects the inverse AES S-box; it is sampled with in_data.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a completed block.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-012 The block SHALL have port out_data, output, 8*NBYTES bits: substituted state, using the same byte order as in_data.
REQ-013 The block SHALL have port busy, output, 1 bit: high in the RUN state.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, RUN and DONE, plus a group counter cnt of max(1, clog2(NBYTES/LANES)) bits.
REQ-015 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready), and SHALL be forced to 0 while clear=1.
REQ-016 A block is accepted on an edge where in_valid and in_ready are both high: in_data is loaded into an internal buffer, in_inv is latched as mode, cnt is set to 0, and the state goes to RUN.
REQ-017 On each RUN edge, buffer bytes cnt*LANES through cnt*LANES+LANES-1 SHALL be replaced by S(byte) when mode=0 or by S^-1(byte) when mode=1, and cnt SHALL increment.
REQ-018 The S-box tables SHALL be the FIPS-197 forward table (e.g. 00->63, 53->ED) and the FIPS-197 inverse table (e.g. 63->00, ED->53).
REQ-019 On the RUN edge that processes group NBYTES/LANES-1, the state SHALL go to DONE; out_valid therefore rises exactly NBYTES/LANES edges after the acceptance edge, which is 1 edge when LANES==NBYTES.
REQ-020 In DONE, out_valid SHALL be 1 and out_data SHALL equal the buffer, held stable until out_ready=1.
REQ-021 In DONE with out_ready=1 and in_valid=0, the state SHALL go to IDLE and out_valid SHALL fall on that edge.
REQ-022 In DONE with out_ready=1 and in_valid=1, the output SHALL be consumed and the new block accepted on the same edge (state to RUN, no idle bubble).
REQ-023 in_valid asserted during RUN SHALL be ignored (in_ready=0), and in_data changes during RUN SHALL NOT affect the block in progress.
REQ-024 clear=1 SHALL, on the next edge, put the block in IDLE with out_valid=0, busy=0 and cnt=0, discarding any partial or pending result; clear takes priority over all other events.
REQ-025 out_data SHALL be don't-care when out_valid=0, except that it SHALL equal 0 after reset until the first load.
REQ-026 The mode latched at acceptance SHALL govern the whole block, regardless of later changes on in_inv.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force state=IDLE, cnt=0, buffer=0 and mode=0, giving out_valid=0, busy=0, in_ready=1 and out_data=0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the block with no output produced; after rst_n deasserts, the first edge with in_valid=1 SHALL be accepted.

Verification
REQ-029 NBYTES=16, LANES=4, forward mode: in_data bytes 0..15 = 00..0F -> after 4 edges out_data bytes = 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76, with busy high for 4 cycles.
REQ-030 Same configuration, inverse mode, applied to the REQ-029 output -> out_data bytes 0..15 = 00..0F.
REQ-031 LANES=16 and LANES=1 with all-zero input -> all bytes 63, with out_valid rising after 1 edge and 16 edges respectively.
REQ-032 Back-to-back: second block presented while DONE and out_ready=1 -> accepted on the same edge, and the second result appears 4 edges later; with out_ready=0 held for 10 cycles, out_data stays stable and in_ready=0.
REQ-033 clear asserted at RUN cycle 2 -> IDLE next edge with out_valid never asserted; rst_n pulsed low in DONE -> outputs return to their reset values immediately, without waiting for a clock edge.
REQ-034 Random stimulus over legal (NBYTES, LANES) pairs with random in_inv and random valid/ready stalls -> every result matches a reference S-box model byte-for-byte, with no lost or duplicated blocks.

Source files
------------

// File: rtl/aes_subbytes_engine.sv
// aes_subbytes_engine: iterative AES SubBytes / InvSubBytes over one state block.
// Each clock in RUN substitutes one group of LANES bytes. The block takes NBYTES/LANES
// clocks, and the caller picks the forward or inverse S-box when the block is accepted.
`timescale 1ns/1ps
module aes_subbytes_engine #(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                busy
);
  localparam int NGROUPS = NBYTES / LANES;
  localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg;
  logic [CW-1:0]       cnt_reg;
  logic [8*NBYTES-1:0] data_reg;
  logic [8*NBYTES-1:0] data_next;
  logic                mode_reg;
  logic [7:0]          lane_in  [LANES];
  logic [7:0]          lane_out [LANES];
  logic                last_group;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // forward S-box: inverse followed by the AES affine transform
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    logic [7:0] s;
    logic [7:0] r;
    v = gf_inv(x);
    s = v;
    r = v ^ 8'h63;
    for (int i = 1; i <= 4; i++) begin
      s = {s[6:0], s[7]};
      r = r ^ s;
    end
    return r;
  endfunction

  // inverse S-box: inverse affine transform followed by the field inverse
  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // select the bytes of the group currently addressed by cnt
  always_comb begin
    for (int l = 0; l < LANES; l++) lane_in[l] = 8'h00;
    for (int g = 0; g < NGROUPS; g++) begin
      if (cnt_reg == CW'(g)) begin
        for (int l = 0; l < LANES; l++) lane_in[l] = data_reg[8*(g*LANES+l) +: 8];
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_out[gi] = mode_reg ? sbox_inv(lane_in[gi]) : sbox_fwd(lane_in[gi]);
  end

  // write the substituted group back into its slot of the buffer
  always_comb begin
    data_next = data_reg;
    for (int g = 0; g < NGROUPS; g++) begin
      if (cnt_reg == CW'(g)) begin
        for (int l = 0; l < LANES; l++) data_next[8*(g*LANES+l) +: 8] = lane_out[l];
      end
    end
  end

  assign last_group = (cnt_reg == CW'(NGROUPS - 1));

  // control FSM: accept -> RUN over all groups -> DONE until consumed; clear aborts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      mode_reg  <= 1'b0;
    end else if (clear) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_reg  <= in_data;
            mode_reg  <= in_inv;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          data_reg <= data_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_group) state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              data_reg  <= in_data;
              mode_reg  <= in_inv;
              cnt_reg   <= '0;
              state_reg <= RUN;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = !clear && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == RUN);
  assign out_data  = data_reg;

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// tb_aes_subbytes_engine: directed checks on a 16/4 engine plus scoreboard-driven
// random traffic on several (NBYTES, LANES) configurations against a table S-box model.
`timescale 1ns/1ps
module tb_aes_subbytes_engine;
  localparam int NCFG = 5;
  localparam int NBLK = 25;
  localparam int CFG_NB [NCFG] = '{16, 16, 16, 8, 12};
  localparam int CFG_LN [NCFG] = '{4, 16, 1, 2, 3};

  localparam logic [127:0] FWD_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] VEC_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] VEC_FWD = 128'h76abd7fe2b670130c56f6bf27b777c63;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic start_rand = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         d_clear, d_in_valid, d_in_ready, d_in_inv, d_out_valid, d_out_ready, d_busy;
  logic [127:0] d_in_data, d_out_data;
  logic [127:0] exp_q [$];

  aes_subbytes_engine #(.NBYTES(16), .LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(d_clear),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_inv(d_in_inv),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .busy(d_busy)
  );

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_fwd(input logic [7:0] x);
    logic [127:0] row;
    row = FWD_ROWS[x[7:4]];
    return row[8*(15-int'(x[3:0])) +: 8];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] y);
    for (int i = 0; i < 256; i++) begin
      if (ref_fwd(8'(i)) == y) return 8'(i);
    end
    return 8'h00;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] data, input logic inv, input int nb);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = inv ? ref_inv(data[8*i +: 8]) : ref_fwd(data[8*i +: 8]);
    return r;
  endfunction

  // accept one block on the 16/4 engine, disturb inputs during RUN, wait for DONE
  task automatic run_block(input logic [127:0] data, input logic inv, output logic [127:0] got);
    int n;
    int busy_n;
    logic [127:0] expv;
    @(negedge clk);
    d_in_valid = 1'b1; d_in_data = data; d_in_inv = inv; d_out_ready = 1'b1;
    #1 check_value("acc_ready", 128'(d_in_ready), 128'(1));
    exp_q.push_back(ref_sub(data, inv, 16));
    @(posedge clk); #1;
    d_in_data = {$urandom, $urandom, $urandom, $urandom};
    d_in_inv = ~inv; d_out_ready = 1'b0;
    n = 0; busy_n = 0;
    while (!d_out_valid && n < 64) begin
      if (d_busy) busy_n++;
      check_value("run_ready", 128'(d_in_ready), 128'(0));
      @(posedge clk); #1;
      n++;
    end
    d_in_valid = 1'b0;
    check_value("latency", 128'(n), 128'(4));
    check_value("busy_cycles", 128'(busy_n), 128'(4));
    if (exp_q.size() == 0) begin
      check_value("dir_queue", 128'(0), 128'(1));
      expv = '0;
    end else begin
      expv = exp_q.pop_front();
      check_value("dir_data", d_out_data, expv);
    end
    got = d_out_data;
    $display("dir blk inv=%0d lat=%0d out=%h", inv, n, d_out_data);
  endtask

  initial begin
    logic [127:0] got;
    logic seen;
    int guard;
    d_clear = 0; d_in_valid = 0; d_in_data = '0; d_in_inv = 0; d_out_ready = 0;
    #1;
    check_value("rst_in_ready", 128'(d_in_ready), 128'(1));
    check_value("rst_out_valid", 128'(d_out_valid), 128'(0));
    check_value("rst_busy", 128'(d_busy), 128'(0));
    check_value("rst_out_data", d_out_data, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // forward vector, then a 10-cycle stall holding the result
    run_block(VEC_IN, 1'b0, got);
    check_value("fwd_vector", got, VEC_FWD);
    repeat (10) begin
      @(posedge clk); #1;
      check_value("stall_valid", 128'(d_out_valid), 128'(1));
      check_value("stall_data", d_out_data, VEC_FWD);
      check_value("stall_ready", 128'(d_in_ready), 128'(0));
    end

    // back-to-back: inverse of the previous result accepted while DONE
    run_block(VEC_FWD, 1'b1, got);
    check_value("inv_vector", got, VEC_IN);
    @(negedge clk); d_out_ready = 1'b1;
    @(posedge clk); #1;
    check_value("consume_valid", 128'(d_out_valid), 128'(0));
    check_value("consume_ready", 128'(d_in_ready), 128'(1));
    d_out_ready = 1'b0;

    // clear during the second RUN cycle
    @(negedge clk);
    d_in_valid = 1'b1; d_in_data = {$urandom, $urandom, $urandom, $urandom}; d_in_inv = 1'b0;
    @(posedge clk); #1; d_in_valid = 1'b0;
    @(posedge clk); #1;
    check_value("clr_busy_pre", 128'(d_busy), 128'(1));
    d_clear = 1'b1;
    #1 check_value("clr_ready", 128'(d_in_ready), 128'(0));
    @(posedge clk); #1;
    d_clear = 1'b0;
    check_value("clr_busy", 128'(d_busy), 128'(0));
    check_value("clr_valid", 128'(d_out_valid), 128'(0));
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (d_out_valid) seen = 1'b1;
    end
    check_value("clr_no_output", 128'(seen), 128'(0));
    d_clear = 1'b1; d_in_valid = 1'b1;
    #1 check_value("clr_idle_ready", 128'(d_in_ready), 128'(0));
    @(posedge clk); #1;
    check_value("clr_no_accept", 128'(d_busy), 128'(0));
    d_clear = 1'b0; d_in_valid = 1'b0;

    // asynchronous reset while DONE, then first block after release
    run_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, got);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_value("arst_valid", 128'(d_out_valid), 128'(0));
    check_value("arst_busy", 128'(d_busy), 128'(0));
    check_value("arst_ready", 128'(d_in_ready), 128'(1));
    check_value("arst_data", d_out_data, 128'(0));
    @(negedge clk); rst_n = 1'b1;
    run_block(VEC_FWD, 1'b1, got);
    check_value("post_rst_vector", got, VEC_IN);
    @(negedge clk); d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    check_value("dir_queue_empty", 128'(exp_q.size()), 128'(0));

    // random traffic on all configurations
    start_rand = 1'b1;
    guard = 0;
    while (done_cnt < NCFG && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check_value("rand_done", 128'(done_cnt), 128'(NCFG));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int NB = CFG_NB[gi];
    localparam int LN = CFG_LN[gi];
    localparam int NG = NB / LN;

    logic              r_clear, r_in_valid, r_in_ready, r_in_inv, r_out_valid, r_out_ready, r_busy;
    logic [8*NB-1:0]   r_in_data, r_out_data;
    logic [127:0]      q [$];
    int                edge_cnt = 0;

    aes_subbytes_engine #(.NBYTES(NB), .LANES(LN)) u_eng (
      .clk(clk), .rst_n(rst_n), .clear(r_clear),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data), .in_inv(r_in_inv),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data), .busy(r_busy)
    );

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
      int nblk;
      int nout;
      int acc_edge;
      int cyc;
      logic prev_ov;
      logic prev_hold;
      logic [127:0] prev_data;
      logic [127:0] dv;
      logic [127:0] expv;
      r_clear = 0; r_in_valid = 0; r_in_data = '0; r_in_inv = 0; r_out_ready = 0;
      nblk = 0; nout = 0; acc_edge = 0; cyc = 0;
      prev_ov = 0; prev_hold = 0; prev_data = '0;
      wait (start_rand);
      while ((nblk < NBLK || q.size() > 0 || r_out_valid) && cyc < 4000) begin
        @(negedge clk);
        cyc++;
        if (prev_hold) begin
          check_value("hold_valid", 128'(r_out_valid), 128'(1));
          check_value("hold_data", 128'(r_out_data), prev_data);
        end
        if (r_out_valid && !prev_ov)
          check_value("rand_latency", 128'(edge_cnt - acc_edge), 128'(NG));
        r_out_ready = (nblk >= NBLK) ? 1'b1 : ($urandom_range(0, 3) != 0);
        dv = {$urandom, $urandom, $urandom, $urandom};
        if (nblk < NBLK && $urandom_range(0, 2) != 0) begin
          r_in_valid = 1'b1;
          if (nblk == 0) dv = '0;
          r_in_inv = (nblk == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        end else begin
          r_in_valid = 1'b0;
          r_in_inv = 1'($urandom_range(0, 1));
        end
        r_in_data = dv[8*NB-1:0];
        #1;
        if (r_out_valid && r_out_ready) begin
          if (q.size() == 0) begin
            check_value("rand_extra", 128'(0), 128'(1));
          end else begin
            expv = q.pop_front();
            check_value("rand_data", 128'(r_out_data), expv);
            $display("cfg%0d n%0d l%0d blk %0d out=%h", gi, NB, LN, nout, r_out_data);
            nout++;
          end
        end
        if (r_in_valid && r_in_ready) begin
          q.push_back(ref_sub(128'(r_in_data), r_in_inv, NB));
          acc_edge = edge_cnt + 1;
          nblk++;
        end
        prev_ov = r_out_valid;
        prev_hold = r_out_valid && !r_out_ready;
        prev_data = 128'(r_out_data);
      end
      r_in_valid = 1'b0;
      check_value("rand_drain", 128'(q.size()), 128'(0));
      check_value("rand_outputs", 128'(nout), 128'(NBLK));
      done_cnt = done_cnt + 1;
    end
  end

endmodule
